// File: rtl/mult_prof_pkg.sv
// rtl/mult_prof_pkg.sv - shared types, LFSR taps, edge-case operand table and width helper
package mult_prof_pkg;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  localparam logic [31:0] TAPS_N8  = 32'h0000_B400;
  localparam logic [31:0] TAPS_N16 = 32'hA300_0000;

  typedef enum logic [1:0] {EC_ZERO, EC_MAX, EC_ONE} edge_code_t;

  localparam edge_code_t EDGE_A [5] = '{EC_ZERO, EC_MAX, EC_ONE, EC_MAX, EC_ZERO};
  localparam edge_code_t EDGE_B [5] = '{EC_ZERO, EC_MAX, EC_ONE, EC_ZERO, EC_MAX};

  function automatic int cnt_width(input int samples);
    return $clog2(samples + 1);
  endfunction

  function automatic logic [31:0] lfsr_taps(input int n);
    return (n == 16) ? TAPS_N16 : TAPS_N8;
  endfunction

  function automatic logic [15:0] edge_operand(input int idx, input logic sel_b, input int n);
    edge_code_t code;
    logic [15:0] maxv;
    maxv = (n == 16) ? 16'hFFFF : 16'h00FF;
    code = sel_b ? EDGE_B[idx % 5] : EDGE_A[idx % 5];
    case (code)
      EC_MAX:  return maxv;
      EC_ONE:  return 16'd1;
      default: return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/mult_prof_lfsr.sv
// rtl/mult_prof_lfsr.sv - 2N-bit right-shifting Galois LFSR operand source
module mult_prof_lfsr
  import mult_prof_pkg::*;
#(
  parameter int              N    = 8,
  parameter logic [2*N-1:0]  SEED = 'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step,
  output logic [2*N-1:0] state
);

  localparam logic [2*N-1:0] TAPS     = (2*N)'(lfsr_taps(N));
  localparam logic [2*N-1:0] SEED_EFF = (SEED == '0) ? (2*N)'(1) : SEED;

  logic [2*N-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step) state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED_EFF;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/mult_error_profiler.sv
// rtl/mult_error_profiler.sv - multiplier stimulus/capture engine; MULT_EDGE_CASES_EN adds edge pairs and approx range check
module mult_error_profiler
  import mult_prof_pkg::*;
#(
  parameter int             N       = 8,
  parameter int             SAMPLES = 256,
  parameter logic [2*N-1:0] SEED    = 'hACE1,
  parameter int             CW      = cnt_width(SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [N-1:0]      op_a,
  output logic [N-1:0]      op_b,
  input  logic [2*N-1:0]    exact_in,
  input  logic [2*N-1:0]    approx_in,
  input  logic [2*N-1:0]    error_in,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [2*N+CW-1:0] err_sum,
  output logic [2*N+CW-1:0] exact_sum,
  output logic [2*N-1:0]    err_max,
  output logic [CW-1:0]     nz_cnt
);

`ifdef MULT_EDGE_CASES_EN
  localparam bit EDGE_EN  = 1'b1;
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit EDGE_EN  = 1'b0;
  localparam bit RANGE_EN = 1'b0;
`endif

  localparam int             AW         = 2*N + CW;
  localparam logic [2*N-1:0] MAXV       = (2*N)'((64'd1 << N) - 64'd1);
  localparam logic [2*N-1:0] APPROX_LIM = MAXV * MAXV;

  state_t          state_q, state_d;
  logic            busy_q, busy_d, valid_q, valid_d;
  logic [N-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CW-1:0]   cnt_q, cnt_d, nz_q, nz_d;
  logic [AW-1:0]   err_sum_q, err_sum_d, exact_sum_q, exact_sum_d;
  logic [2*N-1:0]  err_max_q, err_max_d;
  logic [2*N-1:0]  lfsr_state;
  logic            step, load, sample_nz;
  logic [31:0]     load_idx;

  mult_prof_lfsr #(.N(N), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (step),
    .state (lfsr_state)
  );

  assign sample_nz = (error_in != '0) || (RANGE_EN && (approx_in > APPROX_LIM));

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cnt_d       = cnt_q;
    nz_d        = nz_q;
    err_sum_d   = err_sum_q;
    exact_sum_d = exact_sum_q;
    err_max_d   = err_max_q;
    load        = 1'b0;
    load_idx    = 32'd0;
    step        = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d     = RUN;
        busy_d      = 1'b1;
        cnt_d       = '0;
        nz_d        = '0;
        err_sum_d   = '0;
        exact_sum_d = '0;
        err_max_d   = '0;
        load        = 1'b1;
      end
      RUN: begin
        err_sum_d   = err_sum_q + AW'(error_in);
        exact_sum_d = exact_sum_q + AW'(exact_in);
        err_max_d   = (error_in > err_max_q) ? error_in : err_max_q;
        nz_d        = nz_q + CW'(sample_nz);
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CW'(SAMPLES - 1)) begin
          state_d = REPORT;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          load     = 1'b1;
          load_idx = 32'(cnt_q) + 32'd1;
        end
      end
      REPORT: if (result_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // The LFSR always holds the next unconsumed pair, so it only steps when that pair is taken.
    if (load) begin
      if (EDGE_EN && (load_idx < 32'd5)) begin
        op_a_d = N'(edge_operand(int'(load_idx), 1'b0, N));
        op_b_d = N'(edge_operand(int'(load_idx), 1'b1, N));
      end else begin
        op_a_d = lfsr_state[N-1:0];
        op_b_d = lfsr_state[2*N-1:N];
        step   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      nz_q        <= '0;
      err_sum_q   <= '0;
      exact_sum_q <= '0;
      err_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      nz_q        <= nz_d;
      err_sum_q   <= err_sum_d;
      exact_sum_q <= exact_sum_d;
      err_max_q   <= err_max_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign err_sum      = err_sum_q;
  assign exact_sum    = exact_sum_q;
  assign err_max      = err_max_q;
  assign nz_cnt       = nz_q;

endmodule
